awgn_sweep_ctrl: RTL and testbench

- Scheduler that runs the AWGN channel block across a sweep of SNR points.
- For each point it: holds the channel in reset so its LFSRs re-seed; streams exactly FRAME_LEN source symbols into the channel through a valid/ready handshake; waits for the channel pipeline to drain; then advances the SNR index.
- Supplies the per-point sigma code and tags each channel output with its SNR index for the BER/statistics stage downstream.

---
 rtl/awgn_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_awgn_sweep_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/awgn_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : awgn_sweep_ctrl
//  Purpose  : Runs the AWGN channel block across a sweep of SNR points. For
//             each point the channel is held in reset (LFSR re-seed), exactly
//             FRAME_LEN source symbols are streamed into it, the channel
//             pipeline is drained, and the SNR index advances. Channel outputs
//             are tagged with the SNR index they were generated under.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset           clock (rising edge), asynchronous active-low reset
//    start, abort         sweep start pulse / synchronous abort (abort wins)
//    src_valid/src_ready  source handshake, src_real/src_imag symbol data
//    ch_reset, ch_read    channel reset (active-high) and input strobe
//    ch_x_real/imag       registered symbol presented to the channel
//    ch_y_real/imag       channel output, passed straight to the consumer
//    snr_sel, sigma       current SNR index and its sigma code
//    y_valid, y_snr       ch_y_* valid qualifier and its SNR tag
//    point_done           one-cycle pulse when a point has fully drained
//    busy, done           sweep in progress / sweep complete
// ============================================================================
module awgn_sweep_ctrl #(
  parameter int BI        = 7,
  parameter int SNR_MIN   = 0,
  parameter int SNR_MAX   = 9,
  parameter int FRAME_LEN = 320000,
  parameter int CNT_W     = 19,
  parameter int FLUSH_CYC = 4,
  parameter int CH_LAT    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic [BI-1:0] src_real,
  input  logic [BI-1:0] src_imag,
  output logic          ch_reset,
  output logic          ch_read,
  output logic [BI-1:0] ch_x_real,
  output logic [BI-1:0] ch_x_imag,
  input  logic [BI-1:0] ch_y_real,
  input  logic [BI-1:0] ch_y_imag,
  output logic [3:0]    snr_sel,
  output logic [7:0]    sigma,
  output logic          y_valid,
  output logic [3:0]    y_snr,
  output logic          point_done,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int                FLUSH_W      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FLUSH_W-1:0] C_FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);
  localparam logic [FLUSH_W-1:0] C_FLUSH_ONE  = FLUSH_W'(1);
  localparam logic [CNT_W-1:0]   C_FRAME_LEN  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]   C_LAST_SYM   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]   C_CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]         C_SNR_MIN    = 4'(SNR_MIN);
  localparam logic [3:0]         C_SNR_MAX    = 4'(SNR_MAX);

  state_t                     state_q,     state_d;
  logic [FLUSH_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]           sym_cnt_q,   sym_cnt_d;
  logic [3:0]                 snr_sel_q,   snr_sel_d;
  logic                       ch_read_q,   ch_read_d;
  logic [BI-1:0]              ch_x_real_q, ch_x_real_d;
  logic [BI-1:0]              ch_x_imag_q, ch_x_imag_d;
  // Valid pipe and its parallel SNR tag pipe, aligned to the channel latency.
  logic [CH_LAT-1:0]          vpipe_q,     vpipe_d;
  logic [CH_LAT-1:0][3:0]     tag_q,       tag_d;
  logic                       beat;

  // The channel data goes straight to the consumer alongside y_valid/y_snr;
  // the controller itself never looks at it.
  logic unused_ch_y;
  assign unused_ch_y = ^{ch_y_real, ch_y_imag};

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    snr_sel_d   = snr_sel_q;
    ch_read_d   = 1'b0;
    ch_x_real_d = ch_x_real_q;
    ch_x_imag_d = ch_x_imag_q;
    src_ready   = 1'b0;
    ch_reset    = 1'b1;
    point_done  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    beat        = 1'b0;

    // Tag pipe shifts the current SNR index alongside the read strobe so each
    // y_valid carries the point it was produced under.
    vpipe_d    = vpipe_q;
    tag_d      = tag_q;
    vpipe_d[0] = ch_read_q;
    tag_d[0]   = snr_sel_q;
    for (int i = CH_LAT - 1; i > 0; i--) begin
      vpipe_d[i] = vpipe_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snr_sel_d   = C_SNR_MIN;
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        busy        = 1'b1;
        flush_cnt_d = flush_cnt_q + C_FLUSH_ONE;
        if (flush_cnt_q == C_FLUSH_LAST) begin
          sym_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        busy     = 1'b1;
        ch_reset = 1'b0;
        // Abort removes ready in its own cycle so no beat is taken that the
        // channel would then never see.
        src_ready = (sym_cnt_q < C_FRAME_LEN) && !abort;
        beat      = src_valid && src_ready;
        if (beat) begin
          ch_read_d   = 1'b1;
          ch_x_real_d = src_real;
          ch_x_imag_d = src_imag;
          sym_cnt_d   = sym_cnt_q + C_CNT_ONE;
          if (sym_cnt_q == C_LAST_SYM) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        busy     = 1'b1;
        ch_reset = 1'b0;
        // Empty means the strobe register and every pipe stage are clear,
        // i.e. the final y_valid has already been presented.
        if (!ch_read_q && (vpipe_q == '0)) begin
          point_done = !abort;
          if (snr_sel_q == C_SNR_MAX) begin
            state_d = ST_DONE;
          end else begin
            snr_sel_d   = snr_sel_q + 4'd1;
            flush_cnt_d = '0;
            state_d     = ST_FLUSH;
          end
        end
      end

      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          snr_sel_d   = C_SNR_MIN;
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      snr_sel_d = snr_sel_q;
      ch_read_d = 1'b0;
      vpipe_d   = '0;
      tag_d     = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      sym_cnt_q   <= '0;
      snr_sel_q   <= C_SNR_MIN;
      ch_read_q   <= 1'b0;
      ch_x_real_q <= '0;
      ch_x_imag_q <= '0;
      vpipe_q     <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      snr_sel_q   <= snr_sel_d;
      ch_read_q   <= ch_read_d;
      ch_x_real_q <= ch_x_real_d;
      ch_x_imag_q <= ch_x_imag_d;
      vpipe_q     <= vpipe_d;
      tag_q       <= tag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sigma code per SNR index (roughly a 1 dB step in noise amplitude)
  // --------------------------------------------------------------------------
  always_comb begin
    sigma = 8'd64;
    case (snr_sel_q)
      4'd0:    sigma = 8'd180;
      4'd1:    sigma = 8'd161;
      4'd2:    sigma = 8'd143;
      4'd3:    sigma = 8'd128;
      4'd4:    sigma = 8'd114;
      4'd5:    sigma = 8'd102;
      4'd6:    sigma = 8'd90;
      4'd7:    sigma = 8'd81;
      4'd8:    sigma = 8'd72;
      default: sigma = 8'd64;
    endcase
  end

  assign snr_sel   = snr_sel_q;
  assign ch_read   = ch_read_q;
  assign ch_x_real = ch_x_real_q;
  assign ch_x_imag = ch_x_imag_q;
  assign y_valid   = vpipe_q[CH_LAT-1];
  assign y_snr     = tag_q[CH_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_awgn_sweep_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_awgn_sweep_ctrl
//  Purpose  : Self-checking bench for awgn_sweep_ctrl. A transaction-level
//             model tracks accepted symbols, expected read/valid timing and
//             the sweep progress; a second instance covers the single-point,
//             single-symbol configuration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_awgn_sweep_ctrl;

  localparam int BI        = 7;
  localparam int SNR_MIN   = 7;
  localparam int SNR_MAX   = 8;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 3;
  localparam int FLUSH_CYC = 3;
  localparam int CH_LAT    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort, src_valid, src_ready;
  logic [BI-1:0] src_real, src_imag;
  logic          ch_reset, ch_read;
  logic [BI-1:0] ch_x_real, ch_x_imag, ch_y_real, ch_y_imag;
  logic [3:0]    snr_sel, y_snr;
  logic [7:0]    sigma;
  logic          y_valid, point_done, busy, done;

  logic          start2, abort2, src_valid2, src_ready2;
  logic [BI-1:0] src_real2, src_imag2;
  logic          ch_reset2, ch_read2;
  logic [BI-1:0] ch_x_real2, ch_x_imag2;
  logic [3:0]    snr_sel2, y_snr2;
  logic [7:0]    sigma2;
  logic          y_valid2, point_done2, busy2, done2;

  always #5 clk = ~clk;

  awgn_sweep_ctrl #(
    .BI(BI), .SNR_MIN(SNR_MIN), .SNR_MAX(SNR_MAX), .FRAME_LEN(FRAME_LEN),
    .CNT_W(CNT_W), .FLUSH_CYC(FLUSH_CYC), .CH_LAT(CH_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_real(src_real), .src_imag(src_imag),
    .ch_reset(ch_reset), .ch_read(ch_read),
    .ch_x_real(ch_x_real), .ch_x_imag(ch_x_imag),
    .ch_y_real(ch_y_real), .ch_y_imag(ch_y_imag),
    .snr_sel(snr_sel), .sigma(sigma), .y_valid(y_valid), .y_snr(y_snr),
    .point_done(point_done), .busy(busy), .done(done)
  );

  awgn_sweep_ctrl #(
    .BI(BI), .SNR_MIN(0), .SNR_MAX(0), .FRAME_LEN(1),
    .CNT_W(1), .FLUSH_CYC(FLUSH_CYC), .CH_LAT(CH_LAT)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .src_valid(src_valid2), .src_ready(src_ready2),
    .src_real(src_real2), .src_imag(src_imag2),
    .ch_reset(ch_reset2), .ch_read(ch_read2),
    .ch_x_real(ch_x_real2), .ch_x_imag(ch_x_imag2),
    .ch_y_real(ch_y_real), .ch_y_imag(ch_y_imag),
    .snr_sel(snr_sel2), .sigma(sigma2), .y_valid(y_valid2), .y_snr(y_snr2),
    .point_done(point_done2), .busy(busy2), .done(done2)
  );

  // ---------------- reference model state ----------------
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  bit          sweeping, finished, acc_prev;
  int          exp_snr, exp_run, acc_cnt, rd_cnt, pd_due;
  logic [13:0] q_x[$];
  int          q_due[$];
  int          q_tag[$];

  function automatic int sigma_ref(input int idx);
    int tbl[10] = '{180, 161, 143, 128, 114, 102, 90, 81, 72, 64};
    return (idx > 9) ? 64 : tbl[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sweeping = 1'b0;
    finished = 1'b0;
    acc_prev = 1'b0;
    pd_due   = -1;
    exp_run  = -1;
    acc_cnt  = 0;
    rd_cnt   = 0;
    q_x.delete();
    q_due.delete();
    q_tag.delete();
  endtask

  // One clock cycle: check outputs against the model, then drive inputs.
  // mode 0: src_valid always 1, 1: alternating, 2: random.
  task automatic tick(input bit st, input bit ab, input int mode);
    bit exp_yv;
    @(posedge clk);
    cyc++;
    #1;
    check("sigma", {24'd0, sigma}, sigma_ref(int'(snr_sel)));
    check("ch_read", {31'd0, ch_read}, {31'd0, acc_prev});
    if (ch_read && acc_prev) begin
      check("ch_x", {18'd0, ch_x_real, ch_x_imag}, {18'd0, q_x.pop_front()});
      check("rd_snr", {28'd0, snr_sel}, exp_snr);
      q_due.push_back(cyc + CH_LAT);
      q_tag.push_back(exp_snr);
      rd_cnt++;
    end
    exp_yv = (q_due.size() > 0) && (q_due[0] == cyc);
    check("y_valid", {31'd0, y_valid}, {31'd0, exp_yv});
    if (exp_yv) begin
      check("y_snr", {28'd0, y_snr}, q_tag[0]);
      void'(q_due.pop_front());
      void'(q_tag.pop_front());
      if (q_due.size() == 0 && rd_cnt == FRAME_LEN) pd_due = cyc + 1;
    end
    check("point_done", {31'd0, point_done}, {31'd0, cyc == pd_due});
    check("busy", {31'd0, busy}, {31'd0, sweeping});
    check("done", {31'd0, done}, {31'd0, finished});
    check("ch_reset", {31'd0, ch_reset}, {31'd0, !(sweeping && cyc >= exp_run)});
    if (sweeping || finished) check("snr_sel", {28'd0, snr_sel}, exp_snr);
    if (point_done && cyc == pd_due) begin
      pd_due = -1;
      if (exp_snr == SNR_MAX) begin
        sweeping = 1'b0;
        finished = 1'b1;
      end else begin
        exp_snr++;
        exp_run = cyc + FLUSH_CYC + 1;
        acc_cnt = 0;
        rd_cnt  = 0;
      end
    end

    start     = st;
    abort     = ab;
    src_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
    src_real  = BI'($urandom);
    src_imag  = BI'($urandom);
    #1;
    check("src_ready", {31'd0, src_ready},
          {31'd0, sweeping && cyc >= exp_run && acc_cnt < FRAME_LEN && !ab});
    acc_prev = src_valid && src_ready;
    if (acc_prev) begin
      q_x.push_back({src_real, src_imag});
      acc_cnt++;
    end
    if (st && !sweeping) begin
      sweeping = 1'b1;
      finished = 1'b0;
      exp_snr  = SNR_MIN;
      exp_run  = cyc + FLUSH_CYC + 1;
      acc_cnt  = 0;
      rd_cnt   = 0;
    end
    if (ab) model_reset();
  endtask

  task automatic run_sweep(input int mode, input int budget);
    for (int i = 0; i < budget && !finished; i++) tick(1'b0, 1'b0, mode);
    check("sweep_finished", {31'd0, finished}, 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_ch_reset", {31'd0, ch_reset}, 32'd1);
    check("rst_snr_sel", {28'd0, snr_sel}, SNR_MIN);
    check("rst_sigma", {24'd0, sigma}, 32'd81);
    check("rst_src_ready", {31'd0, src_ready}, 32'd0);
    check("rst_ch_read", {31'd0, ch_read}, 32'd0);
    check("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("rst_point_done", {31'd0, point_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ch_x", {18'd0, ch_x_real, ch_x_imag}, 32'd0);
  endtask

  initial begin
    int reads2, pds2, yv2;
    reset = 1'b0;
    start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_real = '0; src_imag = '0;
    start2 = 1'b0; abort2 = 1'b0; src_valid2 = 1'b0; src_real2 = '0; src_imag2 = '0;
    ch_y_real = '0; ch_y_imag = '0;
    model_reset();
    exp_snr = SNR_MIN;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 0);

    // Full sweep with src_valid held high
    tick(1'b1, 1'b0, 0);
    run_sweep(0, 200);
    repeat (3) tick(1'b0, 1'b0, 0);

    // Start from DONE, alternating src_valid
    tick(1'b1, 1'b0, 1);
    run_sweep(1, 200);

    // Random valid pattern
    tick(1'b1, 1'b0, 2);
    run_sweep(2, 400);

    // Abort after the second channel read of the first point
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < 60 && rd_cnt < 2; i++) tick(1'b0, 1'b0, 0);
    check("abort_setup_reads", rd_cnt, 32'd2);
    tick(1'b0, 1'b1, 0);
    repeat (8) tick(1'b0, 1'b0, 0);
    tick(1'b1, 1'b0, 0);
    run_sweep(0, 200);

    // Start during RUN is ignored
    tick(1'b1, 1'b0, 2);
    for (int i = 0; i < 60 && acc_cnt < 2; i++) tick(1'b0, 1'b0, 2);
    tick(1'b1, 1'b0, 2);
    run_sweep(2, 400);

    // Start and abort together from DONE: abort wins
    tick(1'b1, 1'b1, 0);
    repeat (5) tick(1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of RUN
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < 60 && rd_cnt < 1; i++) tick(1'b0, 1'b0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    repeat (2) tick(1'b0, 1'b0, 0);
    reset = 1'b1;
    repeat (6) tick(1'b0, 1'b0, 0);
    check("post_reset_snr", {28'd0, snr_sel}, SNR_MIN);

    // Single point, single symbol configuration
    reads2 = 0; pds2 = 0; yv2 = 0;
    @(posedge clk);
    #1;
    src_valid2 = 1'b1;
    src_real2  = 7'h2a;
    src_imag2  = 7'h15;
    start2     = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ch_read2) begin
        reads2++;
        check("p2_sigma", {24'd0, sigma2}, 32'd180);
        check("p2_ch_x", {18'd0, ch_x_real2, ch_x_imag2}, {18'd0, 7'h2a, 7'h15});
      end
      if (y_valid2) begin
        yv2++;
        check("p2_y_snr", {28'd0, y_snr2}, 32'd0);
      end
      if (point_done2) pds2++;
      @(posedge clk);
      #1;
    end
    check("p2_reads", reads2, 32'd1);
    check("p2_y_valids", yv2, 32'd1);
    check("p2_point_done", pds2, 32'd1);
    check("p2_done", {31'd0, done2}, 32'd1);
    check("p2_busy", {31'd0, busy2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
